// File: rtl/v74x148_pkg.sv
// v74x148_pkg: shared widths, FSM states and idle code for the registered request encoder
package v74x148_pkg;
    localparam int N_IN = 8;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDLE_CODE_L = 3'b111;
    typedef enum logic [1:0] {IDLE, PRESENT, CLEAR} enc_state_t;
endpackage

// File: rtl/v74x148_prio.sv
// v74x148_prio: highest-set-bit index of a request vector plus an any-set flag
module v74x148_prio
    import v74x148_pkg::*;
(
    input  logic [N_IN-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_IN; i++)
            if (vec[i]) idx = IDX_W'(i);
    end
    assign any_set = |vec;
endmodule

// File: rtl/v74x148_irq_enc.sv
// v74x148_irq_enc: registered 8-to-3 priority request encoder with valid/ack handshake and 74x148-style cascade
module v74x148_irq_enc
    import v74x148_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EI_L,
    input  logic [N_IN-1:0]  I_L,
    input  logic             ACK,
    output logic [IDX_W-1:0] A_L,
    output logic             GS_L,
    output logic             EO_L,
    output logic             OVR
);
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync;
    logic [N_IN-1:0] s_l, s_d, fall, set_ev, clr_mask, pending, pending_nxt;
    logic [IDX_W-1:0] top_idx, cur_idx, a_nxt;
    logic any_set, gs_nxt, eo_nxt, ovr_nxt;
    enc_state_t state, state_nxt;

    assign s_l = sync[SYNC_STAGES-1];
    assign fall = s_d & ~s_l;
    assign set_ev = (EDGE_MODE != 0) ? fall : ~s_l;
    // the clear scheduled by ACK lands during CLEAR; OR-ing sets afterwards lets a colliding set win
    assign clr_mask = (state == CLEAR) ? N_IN'(1) << cur_idx : '0;
    assign pending_nxt = (pending & ~clr_mask) | set_ev;

    v74x148_prio u_prio (
        .vec    (pending),
        .idx    (top_idx),
        .any_set(any_set)
    );

    always_ff @(posedge CLK or posedge RESET)
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = (state == IDLE)    ? ((!EI_L && any_set) ? PRESENT : IDLE) :
                    (state == PRESENT) ? (ACK ? CLEAR : PRESENT) : IDLE;
    end

    // overrun counts only fresh falls, so a held-low line in level mode stays quiet
    always_comb begin
        a_nxt = (state_nxt != PRESENT) ? IDLE_CODE_L : (state == IDLE) ? ~top_idx : ~cur_idx;
        gs_nxt = state_nxt != PRESENT;
        eo_nxt = !(!EI_L && !any_set && state == IDLE && !(|set_ev));
        ovr_nxt = |(fall & pending & ~clr_mask);
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            sync <= '1;
            s_d <= '1;
            pending <= '0;
            cur_idx <= '0;
            A_L <= IDLE_CODE_L;
            GS_L <= 1'b1;
            EO_L <= 1'b1;
            OVR <= 1'b0;
        end else begin
            sync[0] <= I_L;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync[k] <= sync[k-1];
            s_d <= s_l;
            pending <= pending_nxt;
            if (state == IDLE && state_nxt == PRESENT)
                cur_idx <= top_idx;
            A_L <= a_nxt;
            GS_L <= gs_nxt;
            EO_L <= eo_nxt;
            OVR <= ovr_nxt;
        end
endmodule
